pilha_rpn_ctrl: RTL and testbench

PILHA_RPN_CTRL -- requirements
Module: pilha_rpn_ctrl

---
 rtl/pilha_rpn_ctrl_pkg.sv | 16 +
 rtl/pilha_rpn_ctrl_sincroniza_borda.sv | 28 ++
 rtl/pilha_rpn_ctrl.sv | 123 ++++++++++++
 tb/tb_pilha_rpn_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pilha_rpn_ctrl_pkg.sv
// Shared types and sizes for the RPN stack controller: FSM encoding,
// default stack depth and datapath/opcode widths.
package pilha_rpn_ctrl_pkg;

   localparam int PROFUNDIDADE_PADRAO = 4;
   localparam int WIDTH               = 8;
   localparam int OP_W                = 3;
   localparam int NIVEL_W             = 4;

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      EXECUTA = 2'd1,
      GRAVA   = 2'd2
   } estado_t;

endpackage

// File: rtl/pilha_rpn_ctrl_sincroniza_borda.sv
// Two-flop synchronizer for a raw active-low button plus a registered
// one-cycle press strobe; the strobe rises on the third edge after the pin falls.
module sincroniza_borda (
   input  logic clk,
   input  logic rst,
   input  logic tecla_n,
   output logic pulso
);

   logic sinc1, sinc2, anterior;

   // Flops reset to the released level so no strobe fires right after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sinc1    <= 1'b1;
         sinc2    <= 1'b1;
         anterior <= 1'b1;
         pulso    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge value of its source.
         sinc1    <= tecla_n;
         sinc2    <= sinc1;
         anterior <= sinc2;
         pulso    <= anterior & ~sinc2;
      end
   end

endmodule

// File: rtl/pilha_rpn_ctrl.sv
// RPN operand stack controller: pushes operands on a button press and, on the
// operate button, pops two operands and pushes the external ULA result.
module pilha_rpn_ctrl
   import pilha_rpn_ctrl_pkg::*;
#(
   parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO
) (
   input  logic               CLOCK_50,
   input  logic               reset,
   input  logic [WIDTH-1:0]   entrada,
   input  logic               key_num_n,
   input  logic               key_op_n,
   input  logic [OP_W-1:0]    operacao,
   input  logic [WIDTH-1:0]   resultado_ula,
   input  logic               erro_ula,
   output logic [WIDTH-1:0]   display_a,
   output logic [WIDTH-1:0]   display_b,
   output logic [OP_W-1:0]    op_latched,
   output logic [NIVEL_W-1:0] nivel,
   output logic               pilha_vazia,
   output logic               pilha_cheia,
   output logic               op_valida,
   output logic               erro_pilha
);

   logic str_num, str_op;

   sincroniza_borda u_sinc_num (
      .clk     (CLOCK_50),
      .rst     (reset),
      .tecla_n (key_num_n),
      .pulso   (str_num)
   );

   sincroniza_borda u_sinc_op (
      .clk     (CLOCK_50),
      .rst     (reset),
      .tecla_n (key_op_n),
      .pulso   (str_op)
   );

   estado_t            estado, prox_estado;
   logic [WIDTH-1:0]   pilha [PROFUNDIDADE];
   logic [NIVEL_W-1:0] nivel_q;
   logic               cheia, tem_operandos, pedido_op;
   logic               empilhar, iniciar, gravar, sinaliza_erro;

   assign cheia         = (nivel_q == NIVEL_W'(PROFUNDIDADE));
   assign tem_operandos = (nivel_q >= NIVEL_W'(2));
   // A push wins over a simultaneous operate press; the op strobe is dropped.
   assign pedido_op     = str_op & ~str_num;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) estado <= OCIOSO;
      else       estado <= prox_estado;
   end

   always_comb begin
      // NOTE: default assignment first so no path through the case infers a latch.
      prox_estado = estado;
      case (estado)
         OCIOSO:  if (pedido_op && tem_operandos) prox_estado = EXECUTA;
         EXECUTA: prox_estado = GRAVA;
         GRAVA:   prox_estado = OCIOSO;
         default: prox_estado = OCIOSO;
      endcase
   end

   always_comb begin
      empilhar      = 1'b0;
      iniciar       = 1'b0;
      gravar        = 1'b0;
      sinaliza_erro = 1'b0;
      op_valida     = 1'b0;
      case (estado)
         OCIOSO: begin
            empilhar      = str_num & ~cheia;
            iniciar       = pedido_op & tem_operandos;
            sinaliza_erro = (str_num & cheia) | (pedido_op & ~tem_operandos);
         end
         GRAVA: begin
            gravar        = ~erro_ula;
            op_valida     = ~erro_ula;
            sinaliza_erro = erro_ula;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         // NOTE: the stack array is reset because unused entries must read as zero.
         for (int i = 0; i < PROFUNDIDADE; i++) pilha[i] <= '0;
         nivel_q    <= '0;
         op_latched <= '0;
         erro_pilha <= 1'b0;
      end else begin
         if (empilhar) begin
            pilha[0] <= entrada;
            for (int i = 1; i < PROFUNDIDADE; i++) pilha[i] <= pilha[i-1];
            nivel_q    <= nivel_q + NIVEL_W'(1);
            erro_pilha <= 1'b0;
         end
         // Operands A and B collapse into the result; deeper entries move up one slot.
         if (gravar) begin
            pilha[0] <= resultado_ula;
            for (int i = 1; i < PROFUNDIDADE - 1; i++) pilha[i] <= pilha[i+1];
            pilha[PROFUNDIDADE-1] <= '0;
            nivel_q    <= nivel_q - NIVEL_W'(1);
            erro_pilha <= 1'b0;
         end
         if (sinaliza_erro) erro_pilha <= 1'b1;
         if (iniciar)       op_latched <= operacao;
      end
   end

   assign display_a   = pilha[0];
   assign display_b   = tem_operandos ? pilha[1] : '0;
   assign nivel       = nivel_q;
   assign pilha_vazia = (nivel_q == '0);
   assign pilha_cheia = cheia;

endmodule

// File: tb/tb_pilha_rpn_ctrl.sv
// Directed bench for pilha_rpn_ctrl: push/operate sequences with hand-computed
// stack contents, latency, overflow, underflow, ULA error and reset abort.
module tb_pilha_rpn_ctrl;

   localparam logic [2:0] OP_ADD = 3'b001;

   logic       CLOCK_50 = 1'b0;
   logic       reset    = 1'b1;
   logic [7:0] entrada  = 8'h00;
   logic       key_num_n = 1'b1;
   logic       key_op_n  = 1'b1;
   logic [2:0] operacao  = 3'b000;
   logic [7:0] resultado_ula = 8'h00;
   logic       erro_ula  = 1'b0;
   logic [7:0] display_a, display_b;
   logic [2:0] op_latched;
   logic [3:0] nivel;
   logic       pilha_vazia, pilha_cheia, op_valida, erro_pilha;

   int n_cmp = 0;
   int n_err = 0;
   int n_valida = 0;
   int valida_antes;

   pilha_rpn_ctrl #(.PROFUNDIDADE(4)) dut (
      .CLOCK_50      (CLOCK_50),
      .reset         (reset),
      .entrada       (entrada),
      .key_num_n     (key_num_n),
      .key_op_n      (key_op_n),
      .operacao      (operacao),
      .resultado_ula (resultado_ula),
      .erro_ula      (erro_ula),
      .display_a     (display_a),
      .display_b     (display_b),
      .op_latched    (op_latched),
      .nivel         (nivel),
      .pilha_vazia   (pilha_vazia),
      .pilha_cheia   (pilha_cheia),
      .op_valida     (op_valida),
      .erro_pilha    (erro_pilha)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   always @(negedge CLOCK_50) if (op_valida === 1'b1) n_valida++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1);
   end

   task automatic settle();
      @(negedge CLOCK_50);
      key_num_n = 1'b1;
      key_op_n  = 1'b1;
      repeat (4) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
   endtask

   task automatic do_reset();
      @(negedge CLOCK_50);
      reset = 1'b1;
      key_num_n = 1'b1;
      key_op_n  = 1'b1;
      repeat (2) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      reset = 1'b0;
      repeat (2) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
   endtask

   task automatic push(input logic [7:0] v);
      @(negedge CLOCK_50);
      entrada   = v;
      key_num_n = 1'b0;
      repeat (4) @(posedge CLOCK_50);
      settle();
   endtask

   task automatic operate(input logic [2:0] code, input logic [7:0] res);
      @(negedge CLOCK_50);
      operacao      = code;
      resultado_ula = res;
      key_op_n      = 1'b0;
      repeat (6) @(posedge CLOCK_50);
      settle();
   endtask

   task automatic test_reset();
      repeat (3) @(posedge CLOCK_50);
      #1;
      n_cmp++;
      if ({nivel, display_a, display_b, op_latched, pilha_vazia, pilha_cheia, op_valida, erro_pilha} !== {4'd0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_state: got niv=%0d a=%h b=%h op=%0d vaz=%b che=%b val=%b err=%b, expected all 0 with vazia=1",
                  nivel, display_a, display_b, op_latched, pilha_vazia, pilha_cheia, op_valida, erro_pilha);
      end
      @(negedge CLOCK_50);
      reset = 1'b0;
      repeat (2) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
   endtask

   task automatic test_push_latency();
      entrada   = 8'h05;
      key_num_n = 1'b0;
      repeat (3) @(posedge CLOCK_50);
      #1;
      n_cmp++;
      if (nivel !== 4'd0) begin
         n_err++;
         $display("FAIL push_early: nivel=%0d after 3 edges, expected 0", nivel);
      end
      @(posedge CLOCK_50);
      #1;
      n_cmp++;
      if ({display_a, nivel, pilha_vazia} !== {8'h05, 4'd1, 1'b0}) begin
         n_err++;
         $display("FAIL push_latency: a=%h niv=%0d vaz=%b, expected a=05 niv=1 vaz=0", display_a, nivel, pilha_vazia);
      end
      settle();
   endtask

   task automatic test_operation();
      do_reset();
      push(8'h07);
      push(8'h03);
      n_cmp++;
      if ({display_a, display_b, nivel} !== {8'h03, 8'h07, 4'd2}) begin
         n_err++;
         $display("FAIL two_pushes: a=%h b=%h niv=%0d, expected a=03 b=07 niv=2", display_a, display_b, nivel);
      end
      @(negedge CLOCK_50);
      operacao      = OP_ADD;
      resultado_ula = 8'h0A;
      key_op_n      = 1'b0;
      repeat (4) @(posedge CLOCK_50);
      #1;
      n_cmp++;
      if ({op_valida, op_latched} !== {1'b0, OP_ADD}) begin
         n_err++;
         $display("FAIL op_execute: val=%b op=%0d, expected val=0 op=%0d", op_valida, op_latched, OP_ADD);
      end
      @(posedge CLOCK_50);
      #1;
      n_cmp++;
      if (op_valida !== 1'b1) begin
         n_err++;
         $display("FAIL op_valida_pulse: val=%b, expected 1", op_valida);
      end
      @(posedge CLOCK_50);
      #1;
      n_cmp++;
      if ({op_valida, display_a, display_b, nivel, erro_pilha} !== {1'b0, 8'h0A, 8'h00, 4'd1, 1'b0}) begin
         n_err++;
         $display("FAIL op_writeback: val=%b a=%h b=%h niv=%0d err=%b, expected val=0 a=0a b=00 niv=1 err=0",
                  op_valida, display_a, display_b, nivel, erro_pilha);
      end
      settle();
   endtask

   task automatic test_overflow();
      do_reset();
      push(8'h01);
      push(8'h02);
      push(8'h03);
      push(8'h04);
      n_cmp++;
      if ({pilha_cheia, nivel, display_a, display_b, erro_pilha} !== {1'b1, 4'd4, 8'h04, 8'h03, 1'b0}) begin
         n_err++;
         $display("FAIL full: che=%b niv=%0d a=%h b=%h err=%b, expected che=1 niv=4 a=04 b=03 err=0",
                  pilha_cheia, nivel, display_a, display_b, erro_pilha);
      end
      push(8'h09);
      n_cmp++;
      if ({erro_pilha, nivel, display_a, display_b} !== {1'b1, 4'd4, 8'h04, 8'h03}) begin
         n_err++;
         $display("FAIL overflow: err=%b niv=%0d a=%h b=%h, expected err=1 niv=4 a=04 b=03",
                  erro_pilha, nivel, display_a, display_b);
      end
      operate(OP_ADD, 8'h07);
      n_cmp++;
      if ({erro_pilha, pilha_cheia, nivel, display_a, display_b} !== {1'b0, 1'b0, 4'd3, 8'h07, 8'h02}) begin
         n_err++;
         $display("FAIL pop_from_full: err=%b che=%b niv=%0d a=%h b=%h, expected err=0 che=0 niv=3 a=07 b=02",
                  erro_pilha, pilha_cheia, nivel, display_a, display_b);
      end
      operate(OP_ADD, 8'h09);
      n_cmp++;
      if ({nivel, display_a, display_b} !== {4'd2, 8'h09, 8'h01}) begin
         n_err++;
         $display("FAIL pop_shift: niv=%0d a=%h b=%h, expected niv=2 a=09 b=01", nivel, display_a, display_b);
      end
      operate(OP_ADD, 8'h0C);
      n_cmp++;
      if ({nivel, display_a, display_b} !== {4'd1, 8'h0C, 8'h00}) begin
         n_err++;
         $display("FAIL pop_last: niv=%0d a=%h b=%h, expected niv=1 a=0c b=00", nivel, display_a, display_b);
      end
   endtask

   task automatic test_underflow();
      valida_antes = n_valida;
      operate(OP_ADD, 8'h77);
      n_cmp++;
      if ({erro_pilha, nivel, display_a, n_valida == valida_antes} !== {1'b1, 4'd1, 8'h0C, 1'b1}) begin
         n_err++;
         $display("FAIL underflow: err=%b niv=%0d a=%h pulses=%0d, expected err=1 niv=1 a=0c pulses=0",
                  erro_pilha, nivel, display_a, n_valida - valida_antes);
      end
      push(8'h11);
      n_cmp++;
      if ({erro_pilha, nivel, display_a, display_b} !== {1'b0, 4'd2, 8'h11, 8'h0C}) begin
         n_err++;
         $display("FAIL push_clears_err: err=%b niv=%0d a=%h b=%h, expected err=0 niv=2 a=11 b=0c",
                  erro_pilha, nivel, display_a, display_b);
      end
   endtask

   task automatic test_ula_error();
      do_reset();
      push(8'h08);
      push(8'h00);
      erro_ula = 1'b1;
      valida_antes = n_valida;
      operate(3'b100, 8'hFF);
      erro_ula = 1'b0;
      n_cmp++;
      if ({erro_pilha, nivel, display_a, display_b, n_valida == valida_antes} !== {1'b1, 4'd2, 8'h00, 8'h08, 1'b1}) begin
         n_err++;
         $display("FAIL ula_error: err=%b niv=%0d a=%h b=%h pulses=%0d, expected err=1 niv=2 a=00 b=08 pulses=0",
                  erro_pilha, nivel, display_a, display_b, n_valida - valida_antes);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      push(8'h01);
      push(8'h02);
      valida_antes = n_valida;
      @(negedge CLOCK_50);
      entrada       = 8'h33;
      operacao      = 3'b101;
      resultado_ula = 8'h99;
      key_num_n     = 1'b0;
      key_op_n      = 1'b0;
      repeat (8) @(posedge CLOCK_50);
      settle();
      n_cmp++;
      if ({nivel, display_a, display_b, op_latched, n_valida == valida_antes} !== {4'd3, 8'h33, 8'h02, 3'd0, 1'b1}) begin
         n_err++;
         $display("FAIL simultaneous: niv=%0d a=%h b=%h op=%0d pulses=%0d, expected niv=3 a=33 b=02 op=0 pulses=0",
                  nivel, display_a, display_b, op_latched, n_valida - valida_antes);
      end
   endtask

   task automatic test_reset_in_execute();
      do_reset();
      push(8'h04);
      push(8'h05);
      valida_antes = n_valida;
      @(negedge CLOCK_50);
      operacao      = 3'b010;
      resultado_ula = 8'h09;
      key_op_n      = 1'b0;
      repeat (4) @(posedge CLOCK_50);
      #1;
      n_cmp++;
      if (op_latched !== 3'b010) begin
         n_err++;
         $display("FAIL latch_before_abort: op=%0d, expected 2", op_latched);
      end
      @(negedge CLOCK_50);
      reset    = 1'b1;
      key_op_n = 1'b1;
      #1;
      n_cmp++;
      if ({nivel, display_a, display_b, op_latched, op_valida, erro_pilha, pilha_vazia} !== {4'd0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL async_reset: niv=%0d a=%h b=%h op=%0d val=%b err=%b vaz=%b, expected zeros with vazia=1",
                  nivel, display_a, display_b, op_latched, op_valida, erro_pilha, pilha_vazia);
      end
      repeat (3) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      reset = 1'b0;
      repeat (6) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      n_cmp++;
      if ({nivel, display_a, n_valida == valida_antes} !== {4'd0, 8'h00, 1'b1}) begin
         n_err++;
         $display("FAIL abort_no_writeback: niv=%0d a=%h pulses=%0d, expected niv=0 a=00 pulses=0",
                  nivel, display_a, n_valida - valida_antes);
      end
   endtask

   task automatic test_ignored_during_op();
      push(8'h02);
      push(8'h03);
      valida_antes = n_valida;
      @(negedge CLOCK_50);
      operacao      = OP_ADD;
      resultado_ula = 8'h44;
      key_op_n      = 1'b0;
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      entrada   = 8'h55;
      key_num_n = 1'b0;
      repeat (8) @(posedge CLOCK_50);
      settle();
      n_cmp++;
      if ({nivel, display_a, display_b, n_valida - valida_antes} !== {4'd1, 8'h44, 8'h00, 32'd1}) begin
         n_err++;
         $display("FAIL strobe_in_execute: niv=%0d a=%h b=%h pulses=%0d, expected niv=1 a=44 b=00 pulses=1",
                  nivel, display_a, display_b, n_valida - valida_antes);
      end
   endtask

   initial begin
      test_reset();
      test_push_latency();
      test_operation();
      test_overflow();
      test_underflow();
      test_ula_error();
      test_simultaneous();
      test_reset_in_execute();
      test_ignored_during_op();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
